heater_frame_tx: RTL
====================

Name: heater_frame_tx

Overview:
- Consumes the command byte stream delivered by the pseudo-UART read port and drives the heater-bank enables that modulate FPGA temperature for the covert-channel sender.
- Parses one framed command into a local buffer, then replays the payload on-off keyed at a programmable bit period.
- Reports completion or error back through the pseudo-UART write port.

Parameters:
- DATA_WIDTH, 8, byte width of the UART ports.
- MAX_BYTES, 16, payload buffer depth in bytes; must be a power of two.
- NUM_GROUPS, 4, number of heater_en outputs; all are driven identically.
- PERIOD_SHIFT, 10, bit period = (P+1) << PERIOD_SHIFT clk cycles.

Ports:
- clk  in  1  user clock
- rst  in  1  reset, asynchronous, active-high
- data_in_rd_ready  in  1  read FIFO non-empty; data_in valid in the same cycle (first-word fall-through)
- data_in_rd_en  out  1  pop one byte; asserted only when data_in_rd_ready=1
- data_in  in  DATA_WIDTH  current head byte
- data_out_wr_ready  in  1  write FIFO has space
- data_out_wr_en  out  1  push data_out; asserted only when data_out_wr_ready=1
- data_out  out  DATA_WIDTH  status byte
- heater_en  out  NUM_GROUPS  heater bank enables
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous): state=IDLE. All outputs 0: data_in_rd_en, data_out_wr_en, data_out, heater_en, busy. Counters cleared. Buffer contents are don't-care.
- Frame format: 0xA5 (sync), LEN, P, then LEN payload bytes.
- Byte consumption: a byte is consumed in a cycle where data_in_rd_ready=1. data_in_rd_en is combinational, equal to data_in_rd_ready in the parsing states (IDLE, LEN, PERIOD, LOAD) and 0 elsewhere.
- IDLE: consumed byte == 0xA5 -> LEN. Any other byte is discarded and the state stays IDLE.
- LEN: latch LEN. If LEN==0 or LEN>MAX_BYTES -> ERR; otherwise -> PERIOD.
- PERIOD: latch P -> LOAD.
- LOAD: write each consumed byte to buf[byte_idx] and increment byte_idx. After LEN bytes -> TX. Clear the bit counter and period counter.
- TX:
  - Bits are sent MSB-first, byte 0 first. heater_en = {NUM_GROUPS{current bit}}, registered.
  - heater_en changes on the first TX cycle.
  - Each bit holds exactly (P+1)<<PERIOD_SHIFT cycles; the period counter must be at least 8+PERIOD_SHIFT+1 bits wide.
  - After LEN*8 bits -> ACK0, with heater_en forced to 0 on that transition.
  - Input bytes arriving during TX stay in the FIFO; no pop.
- ACK0: present 0x5A on data_out. data_out_wr_en=1 only when data_out_wr_ready=1; advance on that push -> ACK1.
- ACK1: present LEN on data_out; push -> IDLE.
- ERR: present 0xEE; push -> IDLE. No bits are transmitted.
- Write stall: while data_out_wr_ready=0 in ACK0, ACK1 or ERR, hold state and data_out; data_out_wr_en stays 0.
- Counter wrap: the period counter reloads at terminal count. The bit index wraps within a byte; byte_idx increments at each byte boundary.
- Reset mid-TX: heater_en drops to 0 asynchronously and the frame is abandoned; no ack is sent.
- Frame-size arithmetic: MAX_BYTES=16 -> max frame 128 bits.

Optional Feature:
- Macro HEATER_MANCHESTER_EN.
- Defined: each bit period is split into two equal halves.
  - Bit 1 = heater on then off; bit 0 = off then on.
  - The half-period is ((P+1)<<PERIOD_SHIFT)>>1 cycles. P must give an even period, which holds whenever PERIOD_SHIFT>=1.
  - Frame duration is unchanged.
- Undefined: plain on-off keying, as in Behaviour.

Test Plan:
- PERIOD_SHIFT=2. Stream A5,01,00,B4 -> heater_en follows 1,0,1,1,0,1,0,0, each level held 4 cycles. Then data_out pushes 5A, then 01. busy low after the second push.
- Stream 33,A5,02,01,FF,00 -> 0x33 discarded. heater_en high for 64 cycles, then low for 64 cycles. Ack bytes 5A, 02.
- Stream A5,00 -> ERR, data_out=EE, no heater activity. Then A5,11 (LEN=17>16) -> EE. Both frames return to IDLE.
- data_out_wr_ready held 0 for 20 cycles at end of TX -> state held in ACK0 with data_out=5A and data_out_wr_en=0. Release -> 5A, 01 pushed on consecutive ready cycles.
- Assert rst during bit 3 of a frame -> heater_en=0 within the same cycle (async). No ack. A following frame A5,01,00,80 works normally.
- HEATER_MANCHESTER_EN defined, PERIOD_SHIFT=2, frame A5,01,00,80 -> bit 7 gives 2 cycles on, 2 off. Bits 6..0 each give 2 off, 2 on.

Source files
------------

// File: rtl/heater_frame_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | heater_frame_tx_if                                                         |
// | Byte-stream handshake bundle between the heater frame transmitter and the  |
// | pseudo-UART FIFOs.                                                         |
// |   data_in_rd_ready  : read FIFO non-empty, data_in valid (FWFT)            |
// |   data_in_rd_en     : pop one byte from the read FIFO                      |
// |   data_in           : read FIFO head byte                                  |
// |   data_out_wr_ready : write FIFO has space                                 |
// |   data_out_wr_en    : push data_out into the write FIFO                    |
// |   data_out          : status byte                                          |
// | master = transmitter side, slave = FIFO side.                              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface heater_frame_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  data_in_rd_ready;
  logic                  data_in_rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_out_wr_ready;
  logic                  data_out_wr_en;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    input  data_in_rd_ready,
    input  data_in,
    input  data_out_wr_ready,
    output data_in_rd_en,
    output data_out_wr_en,
    output data_out
  );

  modport slave (
    output data_in_rd_ready,
    output data_in,
    output data_out_wr_ready,
    input  data_in_rd_en,
    input  data_out_wr_en,
    input  data_out
  );
endinterface
`default_nettype wire

// File: rtl/heater_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | heater_frame_tx                                                            |
// | Parses a framed command (0xA5, LEN, P, LEN payload bytes) from the         |
// | pseudo-UART read port into a local buffer, replays the payload MSB-first   |
// | as on-off keying of the heater banks with a bit period of                  |
// | (P+1) << PERIOD_SHIFT clocks, then reports 0x5A,LEN (done) or 0xEE (bad    |
// | length) on the pseudo-UART write port.                                     |
// | Ports:                                                                     |
// |   clk       : clock                                                        |
// |   rst       : asynchronous active-high reset                               |
// |   bus       : heater_frame_tx_if.master byte handshake bundle              |
// |   heater_en : NUM_GROUPS heater enables, all driven identically            |
// |   busy      : high in every state except IDLE                              |
// | Optional build macro HEATER_MANCHESTER_EN: each bit period is split into   |
// | two halves (1 = on then off, 0 = off then on), frame length unchanged.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module heater_frame_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BYTES    = 16,
  parameter int NUM_GROUPS   = 4,
  parameter int PERIOD_SHIFT = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  heater_frame_tx_if.master     bus,
  output logic [NUM_GROUPS-1:0] heater_en,
  output logic                  busy
);

  localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  // Wide enough for (P_max+1) << PERIOD_SHIFT without overflow.
  localparam int CNT_W = DATA_WIDTH + PERIOD_SHIFT + 1;

  localparam logic [DATA_WIDTH-1:0] c_SYNC     = DATA_WIDTH'(8'hA5);
  localparam logic [DATA_WIDTH-1:0] c_ACK      = DATA_WIDTH'(8'h5A);
  localparam logic [DATA_WIDTH-1:0] c_ERR      = DATA_WIDTH'(8'hEE);
  localparam logic [DATA_WIDTH-1:0] c_MAX_LEN  = DATA_WIDTH'(MAX_BYTES);
  localparam logic [BIT_W-1:0]      c_BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN    = 3'd1,
    S_PERIOD = 3'd2,
    S_LOAD   = 3'd3,
    S_TX     = 3'd4,
    S_ACK0   = 3'd5,
    S_ACK1   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   len_q, len_d;
  logic [DATA_WIDTH-1:0]   p_q, p_d;
  logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
  logic [BIT_W-1:0]        bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    heat_q, heat_d;
  logic [DATA_WIDTH-1:0]   buf_q [MAX_BYTES];

  logic                    w_buf_we;
  logic                    w_rd_en;
  logic                    w_wr_en;
  logic [DATA_WIDTH-1:0]   w_dout;

  logic [CNT_W-1:0]        w_period_len;
  logic [CNT_W-1:0]        w_period_last;
  logic                    w_load_last;
  logic [DATA_WIDTH-1:0]   w_first_byte;
  logic                    w_bit_wrap;
  logic                    w_last_bit;
  logic [IDX_W-1:0]        w_next_byte_idx;
  logic [BIT_W-1:0]        w_next_bit_idx;
  logic [DATA_WIDTH-1:0]   w_next_byte;
  logic                    w_next_bit;

  assign w_period_len  = (CNT_W'(p_q) + CNT_W'(1)) << PERIOD_SHIFT;
  assign w_period_last = w_period_len - CNT_W'(1);

  // Last payload byte is being consumed in LOAD.
  assign w_load_last = (DATA_WIDTH'(byte_idx_q) == (len_q - DATA_WIDTH'(1)));

  // With a one-byte payload the first byte is still on data_in when TX is
  // entered, so bypass the buffer to present bit 0 on the first TX cycle.
  assign w_first_byte = (byte_idx_q == '0) ? bus.data_in : buf_q[0];

  assign w_bit_wrap      = (bit_idx_q == c_BIT_LAST);
  assign w_last_bit      = w_bit_wrap && w_load_last;
  assign w_next_bit_idx  = bit_idx_q + BIT_W'(1);
  assign w_next_byte_idx = w_bit_wrap ? (byte_idx_q + IDX_W'(1)) : byte_idx_q;
  assign w_next_byte     = buf_q[w_next_byte_idx];
  assign w_next_bit      = w_next_byte[c_BIT_LAST - w_next_bit_idx];

`ifdef HEATER_MANCHESTER_EN
  logic [CNT_W-1:0]        w_half_last;
  logic [DATA_WIDTH-1:0]   w_cur_byte;
  logic                    w_cur_bit;

  assign w_half_last = (w_period_len >> 1) - CNT_W'(1);
  assign w_cur_byte  = buf_q[byte_idx_q];
  assign w_cur_bit   = w_cur_byte[c_BIT_LAST - bit_idx_q];
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    p_d        = p_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    heat_d     = heat_q;
    w_buf_we   = 1'b0;
    w_rd_en    = 1'b0;
    w_wr_en    = 1'b0;
    w_dout     = '0;

    case (state_q)
      S_IDLE: begin
        w_rd_en = bus.data_in_rd_ready;
        if (bus.data_in_rd_ready && (bus.data_in == c_SYNC)) begin
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        w_rd_en = bus.data_in_rd_ready;
        if (bus.data_in_rd_ready) begin
          len_d = bus.data_in;
          if ((bus.data_in == '0) || (bus.data_in > c_MAX_LEN)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_PERIOD;
          end
        end
      end

      S_PERIOD: begin
        w_rd_en = bus.data_in_rd_ready;
        if (bus.data_in_rd_ready) begin
          p_d        = bus.data_in;
          byte_idx_d = '0;
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        w_rd_en = bus.data_in_rd_ready;
        if (bus.data_in_rd_ready) begin
          w_buf_we = 1'b1;
          if (w_load_last) begin
            state_d    = S_TX;
            byte_idx_d = '0;
            bit_idx_d  = '0;
            cnt_d      = '0;
            heat_d     = w_first_byte[DATA_WIDTH-1];
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end
      end

      S_TX: begin
        if (cnt_q == w_period_last) begin
          cnt_d = '0;
          if (w_last_bit) begin
            heat_d  = 1'b0;
            state_d = S_ACK0;
          end else begin
            heat_d     = w_next_bit;
            bit_idx_d  = w_next_bit_idx;
            byte_idx_d = w_next_byte_idx;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`ifdef HEATER_MANCHESTER_EN
          // Second half of the bit carries the complement.
          if (cnt_q == w_half_last) begin
            heat_d = ~w_cur_bit;
          end
`endif
        end
      end

      S_ACK0: begin
        w_dout  = c_ACK;
        w_wr_en = bus.data_out_wr_ready;
        if (bus.data_out_wr_ready) state_d = S_ACK1;
      end

      S_ACK1: begin
        w_dout  = len_q;
        w_wr_en = bus.data_out_wr_ready;
        if (bus.data_out_wr_ready) state_d = S_IDLE;
      end

      S_ERR: begin
        w_dout  = c_ERR;
        w_wr_en = bus.data_out_wr_ready;
        if (bus.data_out_wr_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      p_q        <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      heat_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      p_q        <= p_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      heat_q     <= heat_d;
    end
  end

  // Payload storage carries no reset; contents are only read after LOAD.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      buf_q[byte_idx_q] <= bus.data_in;
    end
  end

  assign bus.data_in_rd_en  = w_rd_en;
  assign bus.data_out_wr_en = w_wr_en;
  assign bus.data_out       = w_dout;
  assign heater_en          = {NUM_GROUPS{heat_q}};
  assign busy               = (state_q != S_IDLE);

endmodule
`default_nettype wire
